// File: rtl/shadow_capture_pkg.sv
// Shared definitions for the shadow capture ring.
//   - dump FSM state encoding (IDLE, LOAD, SHIFT, DONE)
//   - lane_len(): ceiling divide of snapshot bits over output lanes
//   - ptr_w():    ring pointer width, never below 1 bit
package shadow_capture_pkg;

  typedef logic [1:0] dump_state_t;

  localparam dump_state_t StIdle  = 2'd0;
  localparam dump_state_t StLoad  = 2'd1;
  localparam dump_state_t StShift = 2'd2;
  localparam dump_state_t StDone  = 2'd3;

  function automatic int unsigned lane_len(input int unsigned bits, input int unsigned chains);
    return (bits + chains - 1) / chains;
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/shadow_snapshot_ram.sv
// Snapshot storage: DEPTH x W words, one synchronous write port and one
// combinational read port. The dump FSM's LOAD state acts as the read register.
// Ports:
//   clk    in  clock
//   we     in  write enable
//   waddr  in  write slot
//   wdata  in  snapshot word to store
//   raddr  in  read slot
//   rdata  out stored word at raddr (combinational)
module shadow_snapshot_ram #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] mem [DEPTH];

  // No reset: slot contents are only read after being written.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/shadow_capture_ring.sv
// Multi-snapshot shadow capture: freezes up to DEPTH copies of din on
// capture_en and drains them oldest-first over CHAINS_OUT serial lanes
// (LSB first, valid/ready handshake). Lane j carries W[j*L +: L].
// Optional feature macro: SHADOW_CAPTURE_TSTAMP_EN appends a free-running
// TS_WIDTH timestamp in the low bits of each snapshot word.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   capture_en, din  snapshot request and state vector
//   clear            synchronous flush of ring, FSM and overflow
//   dump_req         level request to drain snapshots
//   chains_out       one bit per lane per beat
//   chains_out_vld   beat valid
//   chains_out_rdy   beat accepted when high with vld
//   chains_out_done  one-cycle pulse after the last beat of a snapshot
//   occupancy        stored snapshot count
//   overflow         sticky: a capture was dropped
module shadow_capture_ring
  import shadow_capture_pkg::*;
#(
  parameter int unsigned DFF_BITS   = 64,
  parameter int unsigned CHAINS_OUT = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TS_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       capture_en,
  input  logic [DFF_BITS-1:0]        din,
  input  logic                       clear,
  input  logic                       dump_req,
  output logic [CHAINS_OUT-1:0]      chains_out,
  output logic                       chains_out_vld,
  input  logic                       chains_out_rdy,
  output logic                       chains_out_done,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       overflow
);

`ifdef SHADOW_CAPTURE_TSTAMP_EN
  localparam int unsigned TS_BITS = TS_WIDTH;
`else
  // Timestamp absent; TS_WIDTH kept in the expression only so it stays referenced.
  localparam int unsigned TS_BITS = 0 * TS_WIDTH;
`endif
  localparam int unsigned W_BITS = DFF_BITS + TS_BITS;
  localparam int unsigned L      = lane_len(W_BITS, CHAINS_OUT);
  localparam int unsigned CNT_W  = $clog2(L + 1);
  localparam int unsigned PTR_W  = ptr_w(DEPTH);
  localparam int unsigned OCC_W  = $clog2(DEPTH + 1);
  localparam int unsigned PAD_W  = CHAINS_OUT * L;

  logic [W_BITS-1:0] wdata, rdata;
  logic [PAD_W-1:0]  word_pad;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              ovf_q, ovf_d;
  dump_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [L-1:0]      lane_q [CHAINS_OUT];
  logic [L-1:0]      lane_d [CHAINS_OUT];
  logic              push, pop, beat;

`ifdef SHADOW_CAPTURE_TSTAMP_EN
  logic [TS_WIDTH-1:0] ts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + 1'b1;
  end

  assign wdata = {din, ts_q};
`else
  assign wdata = din;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  shadow_snapshot_ram #(
    .DEPTH (DEPTH),
    .W     (W_BITS),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (push & ~clear),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  // Zero-extend so bits past W_BITS shift out as 0 on the top lane.
  assign word_pad = PAD_W'(rdata);

  always_comb begin
    pop      = (state_q == StDone);
    // A slot freed by this cycle's pop can be refilled in the same cycle.
    push     = capture_en & ((occ_q < OCC_W'(DEPTH)) | pop);
    beat     = (state_q == StShift) & chains_out_rdy;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    lane_d   = lane_q;

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (capture_en & ~push) ovf_d = 1'b1;

    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    case (state_q)
      StIdle: begin
        if (dump_req && occ_q != '0) state_d = StLoad;
      end
      StLoad: begin
        for (int j = 0; j < CHAINS_OUT; j++) lane_d[j] = word_pad[j*L +: L];
        cnt_d   = CNT_W'(L);
        state_d = StShift;
      end
      StShift: begin
        if (beat) begin
          for (int j = 0; j < CHAINS_OUT; j++) lane_d[j] = lane_q[j] >> 1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = StDone;
        end
      end
      StDone: begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        // Occupancy after this pop is nonzero iff it was above 1 now.
        state_d  = (dump_req && occ_q != OCC_W'(1)) ? StLoad : StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      ovf_d    = 1'b0;
      state_d  = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
      state_q  <= StIdle;
      cnt_q    <= '0;
      for (int j = 0; j < CHAINS_OUT; j++) lane_q[j] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      for (int j = 0; j < CHAINS_OUT; j++) lane_q[j] <= lane_d[j];
    end
  end

  assign chains_out_vld  = (state_q == StShift);
  assign chains_out_done = pop & ~clear;
  assign occupancy       = occ_q;
  assign overflow        = ovf_q;

  always_comb begin
    chains_out = '0;
    for (int j = 0; j < CHAINS_OUT; j++) chains_out[j] = chains_out_vld & lane_q[j][0];
  end

endmodule

// File: doc/shadow_capture_ring.md
# shadow_capture_ring

Multi-snapshot shadow capture block: freezes up to `DEPTH` copies of a `DFF_BITS`-wide state vector on capture triggers and drains them oldest-first over `CHAINS_OUT` serial lanes with a valid/ready handshake. It is the parametrised successor to the single-snapshot shadow capture leaf. It adds:
- buffered capture depth
- back-pressure
- overflow reporting
- an optional per-snapshot timestamp

It sits at a leaf of the debug scan tree and feeds a chain arbiter or a host-side deserialiser.

## Interface
- `DFF_BITS`, 64, width of captured state vector (≥1)
- `CHAINS_OUT`, 4, number of serial output lanes (≥1)
- `DEPTH`, 4, snapshot slots in ring (≥1)
- `TS_WIDTH`, 16, timestamp width (used only with `SHADOW_CAPTURE_TSTAMP_EN`)
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `capture_en`  in  1  take snapshot of `din` this cycle
- `din`  in  `DFF_BITS`  state vector to capture
- `clear`  in  1  synchronous flush of ring, dump FSM and overflow
- `dump_req`  in  1  level request to drain snapshots
- `chains_out`  out  `CHAINS_OUT`  serial lane data, one bit per lane per beat
- `chains_out_vld`  out  1  lanes carry a valid beat
- `chains_out_rdy`  in  1  consumer accepts beat when high with vld
- `chains_out_done`  out  1  one-cycle pulse after last beat of a snapshot
- `occupancy`  out  `$clog2(DEPTH+1)`  stored snapshots
- `overflow`  out  1  sticky: a capture was dropped

## Operation
- Snapshot word `W`:
  - without TS: `W` = `din`
  - with TS: `W` = `{din, ts}`, with `ts` in the low bits
- Lane length `L = ceil(|W| / CHAINS_OUT)`.
- Lane j carries `W[j*L +: L]`, LSB first. Bits past `|W|` are shifted out as 0.
- Capture is accepted when `capture_en & (occupancy < DEPTH | pop)`:
  - slot `wr_ptr` is written with `W`
  - `wr_ptr` increments modulo `DEPTH` (wraps to 0)
- Capture not accepted while full: word dropped, `overflow` set, occupancy unchanged.
- `pop` is the cycle the FSM is in DONE. Capture and pop in the same cycle leaves occupancy unchanged.
- Dump FSM states:
  - **IDLE**: goes to LOAD when `dump_req & occupancy != 0`.
  - **LOAD**:
    - copy `ring[rd_ptr]` into `CHAINS_OUT` shift registers
    - beat counter := `L`
    - go to SHIFT
  - **SHIFT**:
    - `vld` = 1
    - on `vld & rdy`: shift every lane right by 1 and decrement the counter
    - when the counter reaches 0, go to DONE
  - **DONE**:
    - `done` = 1, `vld` = 0
    - `rd_ptr++` mod `DEPTH`, occupancy decrements (pop)
    - next state is LOAD if `dump_req & occupancy_after_pop != 0`, else IDLE
- `dump_req` falling mid-snapshot does not abort the snapshot; it only stops the next one.
- `clear` has priority over capture and dump:
  - pointers, occupancy and `overflow` go to 0
  - FSM goes to IDLE
  - no `done` pulse is issued
- Timestamp is a free-running `TS_WIDTH` counter, incremented every cycle, wrapping mod 2^`TS_WIDTH`. The sampled value is the counter value in the capture cycle.

## Timing
- Reset (`rst_n` low, asynchronous): all outputs 0, occupancy 0, overflow 0, ts 0, FSM IDLE. Ring contents are don't-care.
- Capture at edge t: occupancy visible at t+1.
- `dump_req` high and non-empty in IDLE at edge t: LOAD at t+1, first valid beat at t+2.
- Beat rules:
  - data and `vld` are held stable while `rdy` is low
  - `rdy` is ignored when `vld` is low
- Unstalled snapshot takes `L+2` cycles (LOAD + L beats + DONE). Back-to-back snapshots have a 2-cycle gap between last and first beats.
- `overflow` rises the cycle after the dropped capture.
- Beat counter width is `$clog2(L+1)`. Pointer width is `$clog2(DEPTH)`, with minimum 1.

## Configuration
- `SHADOW_CAPTURE_TSTAMP_EN`:
  - defined: the timestamp counter exists, `W = DFF_BITS + TS_WIDTH`, and `L` grows accordingly
  - undefined: no counter, `W = DFF_BITS`, and `TS_WIDTH` is unused

## Structure
- Package `shadow_capture_pkg` holds:
  - the dump FSM state enum (IDLE, LOAD, SHIFT, DONE)
  - a `lane_len(bits, chains)` ceiling-divide function
  - a `ptr_w(depth)` helper
- Sub-module `shadow_snapshot_ram`:
  - `DEPTH` x `W` storage
  - one write port and one combinational read port
  - the LOAD state provides the read register

## Test plan
- `DFF_BITS`=8, `CHAINS_OUT`=2, `DEPTH`=2, TS off; capture `din`=0xA5, then `dump_req`, `rdy`=1 → exactly four `vld` beats, then a `done` pulse; occupancy returns to 0.
  - lane0 sequence: 1,0,1,0
  - lane1 sequence: 0,1,0,1
- Same config, three captures with no dump → occupancy=2, overflow=1. Draining yields the first two `din` values in order; the third value never appears.
- Dump with `rdy` low for 3 cycles after beat 2 → `vld` and lane data held constant; snapshot completes in `L+2+3` = 9 cycles.
- Ring full, capture asserted in the DONE cycle → capture accepted, occupancy stays 2, overflow stays 0.
- `rst_n` low during SHIFT → all outputs 0 immediately without a clock edge; after release, occupancy 0 and no `done` pulse. Also `clear` mid-SHIFT → IDLE next cycle, overflow 0, no `done` pulse.
- With `SHADOW_CAPTURE_TSTAMP_EN`, `DFF_BITS`=8, `TS_WIDTH`=4, `CHAINS_OUT`=2 → `L`=6. Captures 5 cycles apart dump with timestamp fields differing by 5; the timestamp wraps from 15 to 0.
